// File: rtl/s4ga_pipe.sv
// s4ga_pipe: serial LUT-frame evaluator; each record (K index fields, then a mask) yields one LUT output bit.
// Optional S4GA_PIPE_SNAPSHOT_EN makes out a register captured at frame end instead of a live view.
module s4ga_pipe #(
  parameter int N     = 64,
  parameter int K     = 5,
  parameter int SI_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SI_W-1:0]  si,
  input  logic             si_valid,
  output logic [OUT_W-1:0] out,
  output logic             lut_valid,
  output logic             frame_done
);

  localparam int N_W       = $clog2(N);
  localparam int MASK_W    = 1 << K;
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W;
  localparam int MAX_SEGS  = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
  localparam int ACC_W     = MAX_SEGS * SI_W;
  localparam int SEG_W     = (MAX_SEGS > 1) ? $clog2(MAX_SEGS) : 1;
  localparam int K_W       = $clog2(K + 1);

  logic [N-1:0]     r_luts;
  logic [K-1:0]     r_ins;
  logic [N_W-1:0]   r_n;
  logic [K_W-1:0]   r_k;
  logic [SEG_W-1:0] r_seg;
  logic [ACC_W-1:0] r_acc;
  logic             r_lut_valid;
  logic             r_frame_done;

  logic [ACC_W-1:0]  w_field;
  logic [N_W-1:0]    w_idx;
  logic [MASK_W-1:0] w_mask;
  logic              w_idx_phase;
  logic              w_seg_last;
  logic              w_lut_bit;
  logic              w_eval_bit;
  logic              w_eval;
  logic [N-1:0]      w_luts_nxt;

  // Field assembled MSB-segment first; the low bits of a field never contain stale segments.
  assign w_field     = (r_acc << SI_W) | ACC_W'(si);
  assign w_idx       = w_field[N_W-1:0];
  assign w_mask      = w_field[MASK_W-1:0];
  assign w_idx_phase = (r_k < K_W'(K));
  assign w_seg_last  = w_idx_phase ? (r_seg == SEG_W'(IDX_SEGS - 1))
                                   : (r_seg == SEG_W'(MASK_SEGS - 1));
  assign w_lut_bit   = r_luts[w_idx];
  assign w_eval_bit  = w_mask[r_ins];
  assign w_eval      = si_valid && !w_idx_phase && w_seg_last;
  assign w_luts_nxt  = N'({r_luts, w_eval_bit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_luts       <= '0;
      r_ins        <= '0;
      r_n          <= '0;
      r_k          <= '0;
      r_seg        <= '0;
      r_acc        <= '0;
      r_lut_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_lut_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (si_valid) begin
        r_acc <= w_field;
        if (!w_seg_last) begin
          r_seg <= r_seg + SEG_W'(1);
        end else begin
          r_seg <= '0;
          if (w_idx_phase) begin
            r_ins <= K'({r_ins, w_lut_bit});
            r_k   <= r_k + K_W'(1);
          end else begin
            r_luts       <= w_luts_nxt;
            r_k          <= '0;
            r_lut_valid  <= 1'b1;
            r_frame_done <= (r_n == N_W'(N - 1));
            r_n          <= r_n + N_W'(1);
          end
        end
      end
    end
  end

  assign lut_valid  = r_lut_valid;
  assign frame_done = r_frame_done;

`ifdef S4GA_PIPE_SNAPSHOT_EN
  logic [OUT_W-1:0] r_out;

  // Captured on the same edge that raises frame_done, so out and the pulse line up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_eval && (r_n == N_W'(N - 1))) begin
      r_out <= w_luts_nxt[OUT_W-1:0];
    end
  end

  assign out = r_out;
`else
  assign out = r_luts[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_s4ga_pipe.sv
// Randomized bench for s4ga_pipe (N=16,K=4,SI_W=4,OUT_W=8) against a history-based LUT model.
module tb_s4ga_pipe;
  localparam int N = 16;
  localparam int K = 4;
  localparam int SI_W = 4;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SI_W-1:0]  si = '0;
  logic             si_valid = 1'b0;
  logic [OUT_W-1:0] out;
  logic             lut_valid;
  logic             frame_done;

  int checks = 0;
  int errors = 0;
  int fd_count = 0;

  bit         m_hist[N];
  int         m_n;
  logic [7:0] m_snap;

  s4ga_pipe #(.N(N), .K(K), .SI_W(SI_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .si(si), .si_valid(si_valid),
    .out(out), .lut_valid(lut_valid), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] live_window();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_hist[i];
    return v;
  endfunction

  function automatic logic [7:0] exp_out();
`ifdef S4GA_PIPE_SNAPSHOT_EN
    return m_snap;
`else
    return live_window();
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_hist[i] = 1'b0;
    m_n = 0;
    m_snap = 8'h00;
  endtask

  // m_hist[i] is the output produced i+1 evaluations ago; the first index listed drives the mask MSB.
  task automatic model_eval(input logic [15:0] idxs, input logic [15:0] mask, output bit fd);
    int ins;
    bit b;
    ins = 0;
    for (int j = 0; j < K; j++)
      if (m_hist[idxs[4*j +: 4]]) ins += (1 << (K - 1 - j));
    b = mask[ins];
    for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = b;
    fd = (m_n == N - 1);
    if (fd) m_snap = live_window();
    m_n = (m_n + 1) % N;
  endtask

  task automatic step_check(input string tag, input bit lv, input bit fd);
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_count++;
    chk({tag, "_lut_valid"}, 32'(lut_valid), 32'(lv));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(fd));
    chk({tag, "_out"}, 32'(out), 32'(exp_out()));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      si_valid = 1'b0;
      si = 4'($urandom);
      step_check("idle", 1'b0, 1'b0);
    end
  endtask

  task automatic send_record(input logic [15:0] idxs, input logic [15:0] mask,
                            input int gap_at, input int gap_len, input bit rnd);
    bit fd;
    for (int s = 0; s < 8; s++) begin
      if (rnd) idle($urandom_range(0, 2));
      if (s == gap_at) idle(gap_len);
      si = (s < 4) ? idxs[4*s +: 4] : mask[4*(7-s) +: 4];
      si_valid = 1'b1;
      fd = 1'b0;
      if (s == 7) model_eval(idxs, mask, fd);
      step_check("seg", s == 7, fd);
    end
    si_valid = 1'b0;
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_out"}, 32'(out), 32'h0);
    chk({tag, "_lut_valid"}, 32'(lut_valid), 32'h0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    si_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_lut_valid", 32'(lut_valid), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single identity-of-one record: all indices 0, mask all ones.
    send_record(16'h0000, 16'hFFFF, -1, 0, 1'b0);
`ifdef S4GA_PIPE_SNAPSHOT_EN
    chk("one_rec_out", 32'(out), 32'h00);
`else
    chk("one_rec_out", 32'(out), 32'h01);
`endif
    pulse_reset("async_rst_after_eval");

    send_record(16'h0000, 16'hFFFF, 4, 3, 1'b0);
`ifdef S4GA_PIPE_SNAPSHOT_EN
    chk("gap_rec_out", 32'(out), 32'h00);
`else
    chk("gap_rec_out", 32'(out), 32'h01);
`endif
    idle(1);

    // Partial record discarded by reset; the next full record must be LUT 0.
    for (int s = 0; s < 4; s++) begin
      si = 4'($urandom);
      si_valid = 1'b1;
      step_check("partial", 1'b0, 1'b0);
    end
    pulse_reset("async_rst_mid_record");
    send_record(16'h0000, 16'hFFFF, -1, 0, 1'b0);
    idle(1);
    pulse_reset("async_rst_clean");

    // Inverter chain over two frames.
    fd_count = 0;
    for (int r = 1; r <= 32; r++) begin
      send_record(16'h0000, 16'h5555, -1, 0, 1'b0);
      if (r == 8) begin
`ifdef S4GA_PIPE_SNAPSHOT_EN
        chk("inv_lut8_out", 32'(out), 32'h00);
`else
        chk("inv_lut8_out", 32'(out), 32'hAA);
`endif
      end
      if (r == 16) chk("inv_lut16_out", 32'(out), 32'hAA);
      if (r == 24) chk("inv_lut24_out", 32'(out), 32'hAA);
    end
    chk("inv_frame_done_count", 32'(fd_count), 32'd2);
    chk("inv_lut32_out", 32'(out), 32'hAA);
    idle(2);

    // Random records with random idle gaps; n continues from the wrap above.
    for (int r = 0; r < 40; r++)
      send_record(16'($urandom), 16'($urandom), -1, 0, 1'b1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
